// File: rtl/y86_data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// y86_data_mem_responder_if
//   Request/response bus between the Y86 memory stage (master) and the data
//   memory responder (slave).
//
//   Handshake rules, for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both 1. Once a producer raises valid, it
//   keeps valid and its payload stable until that edge. A consumer may drive
//   ready regardless of valid. Ready seen while valid is 0 has no effect.
//
//   Request channel  : req_valid, req_write, req_addr, req_wdata (master -> slave)
//                      req_ready (slave -> master)
//   Response channel : rsp_valid, rsp_rdata, rsp_err (slave -> master)
//                      rsp_ready (master -> slave)
// ----------------------------------------------------------------------------
interface y86_data_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/y86_data_mem_responder.sv
// ----------------------------------------------------------------------------
// y86_data_mem_responder
//   Byte-addressed data memory for the Y86 memory stage. Serves one 8-byte
//   little-endian read or write at a time. An accepted request spends LATENCY
//   wait cycles, and then a response is held until the processor takes it.
//   Any address whose 8-byte window does not fit in MEM_BYTES is reported
//   through rsp_err and leaves the memory untouched. Reset clears the control
//   state only. The memory contents survive reset.
//
//   Parameters : MEM_BYTES - memory size in bytes (multiple of 8, >= 16)
//                LATENCY   - wait cycles per access (0..15)
//   Ports      : clock     - rising-edge clock
//                reset     - synchronous, active-high
//                bus       - slave side of y86_data_mem_responder_if
//                busy      - high whenever the FSM is not IDLE
//                fsm_state - current FSM state (IDLE=0, WAIT=1, RESP=2)
// ----------------------------------------------------------------------------
module y86_data_mem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  y86_data_mem_responder_if.slave  bus,
  output logic                     busy,
  output logic [1:0]               fsm_state
);

  localparam int          AW      = $clog2(MEM_BYTES);
  // Highest start address whose 8-byte window still fits.
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      st;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [63:0] rsp_rdata_q;

  logic [7:0]  mem [MEM_BYTES];

  logic        op_write;
  logic [63:0] op_addr;
  logic [63:0] op_wdata;
  logic        op_bad;
  logic [AW-1:0] base;
  logic [63:0] rd_word;
  logic        enter_resp;

  // The access resolves on the edge that enters RESP. With LATENCY=0 that is
  // the accepting edge itself, so the operands come straight from the bus.
  // In every other case they come from the latched copy.
  always_comb begin
    if (st == IDLE) begin
      op_write = bus.req_write;
      op_addr  = bus.req_addr;
      op_wdata = bus.req_wdata;
    end else begin
      op_write = lat_write;
      op_addr  = lat_addr;
      op_wdata = lat_wdata;
    end
    // Full 64-bit compare, so that high addresses cannot wrap into range.
    op_bad     = (op_addr > LAST_OK);
    base       = op_addr[AW-1:0];
    enter_resp = !reset &&
                 (((st == IDLE) && bus.req_valid && (LATENCY == 0)) ||
                  ((st == WAIT) && (cnt == 4'd0)));
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem[base + AW'(i)];
    end
  end

  // The memory array has no reset, so its contents persist across reset.
  always_ff @(posedge clock) begin
    if (enter_resp && op_write && !op_bad) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + AW'(i)] <= op_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= IDLE;
      cnt         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy        <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write   <= bus.req_write;
            lat_addr    <= bus.req_addr;
            lat_wdata   <= bus.req_wdata;
            req_ready_q <= 1'b0;
            busy        <= 1'b1;
            if (LATENCY == 0) begin
              st <= RESP;
            end else begin
              st  <= WAIT;
              cnt <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) st <= RESP;
          else             cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            st          <= IDLE;
            req_ready_q <= 1'b1;
            busy        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end
        end
        default: st <= IDLE;
      endcase
      // Response payload is captured once on entry and then held until taken.
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= op_bad;
        rsp_rdata_q <= (op_write || op_bad) ? 64'd0 : rd_word;
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign fsm_state     = st;

endmodule

// File: tb/tb_y86_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_y86_data_mem_responder
//   Two responders share a clock and reset. Instance 0 uses LATENCY=2 and
//   instance 1 uses LATENCY=0, and both use MEM_BYTES=1024. A transaction-level
//   model tracks each instance: whether a request is outstanding, how many
//   edges have passed since it was accepted, and the expected memory bytes.
//   From that model, a negedge process derives req_ready, busy, rsp_valid and
//   the response payload. Directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_y86_data_mem_responder;

  localparam int MEM_BYTES = 1024;
  localparam int LAT_A     = 2;
  localparam int LAT_B     = 0;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  y86_data_mem_responder_if bus_a ();
  y86_data_mem_responder_if bus_b ();

  logic       busy_a, busy_b;
  logic [1:0] st_a, st_b;

  y86_data_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT_A)) u_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave), .busy(busy_a), .fsm_state(st_a)
  );
  y86_data_mem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT_B)) u_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave), .busy(busy_b), .fsm_state(st_b)
  );

  // Driven inputs and observed outputs, indexed by instance.
  logic        d_valid [2];
  logic        d_write [2];
  logic [63:0] d_addr  [2];
  logic [63:0] d_wdata [2];
  logic        d_rready[2];

  logic        o_req_ready[2];
  logic        o_rsp_valid[2];
  logic        o_rsp_err  [2];
  logic        o_busy     [2];
  logic [63:0] o_rdata    [2];

  assign bus_a.req_valid = d_valid[0];
  assign bus_a.req_write = d_write[0];
  assign bus_a.req_addr  = d_addr[0];
  assign bus_a.req_wdata = d_wdata[0];
  assign bus_a.rsp_ready = d_rready[0];
  assign bus_b.req_valid = d_valid[1];
  assign bus_b.req_write = d_write[1];
  assign bus_b.req_addr  = d_addr[1];
  assign bus_b.req_wdata = d_wdata[1];
  assign bus_b.rsp_ready = d_rready[1];

  assign o_req_ready[0] = bus_a.req_ready;
  assign o_rsp_valid[0] = bus_a.rsp_valid;
  assign o_rsp_err[0]   = bus_a.rsp_err;
  assign o_rdata[0]     = bus_a.rsp_rdata;
  assign o_busy[0]      = busy_a;
  assign o_req_ready[1] = bus_b.req_ready;
  assign o_rsp_valid[1] = bus_b.rsp_valid;
  assign o_rsp_err[1]   = bus_b.rsp_err;
  assign o_rdata[1]     = bus_b.rsp_rdata;
  assign o_busy[1]      = busy_b;

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          inflight[2];
  int          age     [2];
  bit          m_write [2];
  logic [63:0] m_addr  [2];
  logic [63:0] m_wdata [2];
  logic [63:0] e_rdata [2];
  logic        e_err   [2];
  logic [7:0]  mm      [2][MEM_BYTES];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  // The access takes effect when the response appears.
  task automatic resolve(input int k);
    if (m_addr[k] > 64'(MEM_BYTES - 8)) begin
      e_err[k]   = 1'b1;
      e_rdata[k] = '0;
    end else begin
      e_err[k]   = 1'b0;
      e_rdata[k] = '0;
      for (int i = 0; i < 8; i++) begin
        if (m_write[k]) mm[k][int'(m_addr[k]) + i] = m_wdata[k][8*i +: 8];
        else            e_rdata[k][8*i +: 8] = mm[k][int'(m_addr[k]) + i];
      end
    end
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        inflight[k] = 1'b0;
      end else if (!inflight[k]) begin
        if (d_valid[k]) begin
          inflight[k] = 1'b1;
          age[k]      = 0;
          m_write[k]  = d_write[k];
          m_addr[k]   = d_addr[k];
          m_wdata[k]  = d_wdata[k];
          if (lat_of(k) == 0) resolve(k);
        end
      end else if (age[k] >= lat_of(k)) begin
        if (d_rready[k]) inflight[k] = 1'b0;
      end else begin
        age[k]++;
        if (age[k] == lat_of(k)) resolve(k);
      end
    end
  end

  // One compare process, sampling on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit exp_v;
        exp_v = inflight[k] && (age[k] >= lat_of(k));
        check($sformatf("u%0d.req_ready", k), {63'd0, o_req_ready[k]}, {63'd0, !inflight[k]});
        check($sformatf("u%0d.busy", k),      {63'd0, o_busy[k]},      {63'd0, inflight[k]});
        check($sformatf("u%0d.rsp_valid", k), {63'd0, o_rsp_valid[k]}, {63'd0, exp_v});
        if (exp_v) begin
          check($sformatf("u%0d.rsp_err", k),   {63'd0, o_rsp_err[k]}, {63'd0, e_err[k]});
          check($sformatf("u%0d.rsp_rdata", k), o_rdata[k],            e_rdata[k]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input int k, input bit w, input logic [63:0] a,
                       input logic [63:0] wd, output bit ok);
    bit rdy;
    d_write[k] = w;
    d_addr[k]  = a;
    d_wdata[k] = wd;
    d_valid[k] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = o_req_ready[k];
      @(posedge clock); #1;
      if (rdy) ok = 1'b1;
    end
    d_valid[k] = 1'b0;
    if (!ok) check($sformatf("u%0d.accept_timeout", k), 64'd0, 64'd1);
  endtask

  // Waits for the response while scrambling the request inputs and rsp_ready.
  // Holds rsp_ready low for 'hold' cycles, and then completes the handshake.
  task automatic finish(input int k, input int hold, output logic [63:0] rd,
                        output logic err, output int lat);
    lat = 0;
    while (!o_rsp_valid[k] && lat < 40) begin
      d_valid[k]  = 1'($urandom_range(0, 1));
      d_write[k]  = 1'($urandom_range(0, 1));
      d_addr[k]   = {$urandom, $urandom};
      d_wdata[k]  = {$urandom, $urandom};
      d_rready[k] = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      lat++;
    end
    rd  = o_rdata[k];
    err = o_rsp_err[k];
    if (!o_rsp_valid[k]) begin
      check($sformatf("u%0d.rsp_timeout", k), 64'd0, 64'd1);
      d_valid[k]  = 1'b0;
      d_rready[k] = 1'b0;
    end else begin
      d_rready[k] = 1'b0;
      for (int i = 0; i < hold; i++) begin
        d_valid[k] = 1'($urandom_range(0, 1));
        d_addr[k]  = {$urandom, $urandom};
        @(posedge clock); #1;
      end
      d_valid[k]  = 1'b0;
      d_rready[k] = 1'b1;
      @(posedge clock); #1;
      d_rready[k] = 1'b0;
    end
  endtask

  task automatic txn(input int k, input bit w, input logic [63:0] a, input logic [63:0] wd,
                     input int hold, output logic [63:0] rd, output logic err, output int lat);
    bit ok;
    issue(k, w, a, wd, ok);
    if (ok) finish(k, hold, rd, err, lat);
    else begin
      rd = '0; err = 1'b0; lat = -1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [63:0] rd;
  logic        err;
  int          lat;
  bit          ok;
  bit          b2b_w [3] = '{1'b1, 1'b1, 1'b0};
  logic [63:0] b2b_a [3] = '{64'h48, 64'h50, 64'h48};
  logic [63:0] b2b_d [3] = '{64'hCAFE_0000_1111_0048, 64'hCAFE_0000_2222_0050, 64'h0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      d_valid[k] = 1'b0; d_write[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_rready[k] = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    chk_en = 1'b1;
    @(posedge clock); #1;
    check("reset.req_ready", {63'd0, o_req_ready[0]}, 64'd1);
    check("reset.busy",      {63'd0, o_busy[0]},      64'd0);
    check("reset.rsp_valid", {63'd0, o_rsp_valid[0]}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Preload known bytes that later reads overlap.
    txn(0, 1'b1, 64'h18, 64'hFEDC_BA98_7654_3210, 0, rd, err, lat);
    txn(0, 1'b1, 64'h20, 64'h1111_2222_3333_4444, 0, rd, err, lat);
    txn(0, 1'b1, 64'd1016, 64'hA5A5_0000_FFFF_1234, 1, rd, err, lat);

    // Write at 0x10: response after LATENCY edges, no error.
    txn(0, 1'b1, 64'h10, 64'h0123_4567_89AB_CDEF, 0, rd, err, lat);
    check("wr10.latency", 64'(lat), 64'd2);
    check("wr10.err",     {63'd0, err}, 64'd0);
    check("wr10.rdata",   rd, 64'd0);
    txn(0, 1'b0, 64'h10, 64'h0, 0, rd, err, lat);
    check("rd10.rdata", rd, 64'h0123_4567_89AB_CDEF);

    // Unaligned read across the 0x10 and 0x18 writes.
    txn(0, 1'b0, 64'h12, 64'h0, 0, rd, err, lat);
    check("rd12.rdata", rd, 64'h3210_0123_4567_89AB);

    // Boundary addresses.
    txn(0, 1'b0, 64'd1017, 64'h0, 0, rd, err, lat);
    check("rd1017.err",   {63'd0, err}, 64'd1);
    check("rd1017.rdata", rd, 64'd0);
    txn(0, 1'b0, 64'd1016, 64'h0, 0, rd, err, lat);
    check("rd1016.err",   {63'd0, err}, 64'd0);
    check("rd1016.rdata", rd, 64'hA5A5_0000_FFFF_1234);
    txn(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5555_5555_5555_5555, 0, rd, err, lat);
    check("wrneg.err", {63'd0, err}, 64'd1);
    txn(0, 1'b0, 64'd1016, 64'h0, 0, rd, err, lat);
    check("rd1016_after_bad.rdata", rd, 64'hA5A5_0000_FFFF_1234);

    // Response held for 5 cycles with rsp_ready low.
    txn(0, 1'b0, 64'h18, 64'h0, 5, rd, err, lat);
    check("hold.rdata", rd, 64'hFEDC_BA98_7654_3210);
    check("hold.idle_after", {63'd0, o_req_ready[0]}, 64'd1);

    // Reset one cycle after accepting a write aborts the write.
    issue(0, 1'b1, 64'h20, 64'hDEAD_BEEF_DEAD_BEEF, ok);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort.busy", {63'd0, o_busy[0]}, 64'd0);
    reset = 1'b0;
    txn(0, 1'b0, 64'h20, 64'h0, 0, rd, err, lat);
    check("abort.rd20", rd, 64'h1111_2222_3333_4444);

    // Reset during RESP keeps an already committed write.
    issue(0, 1'b1, 64'h28, 64'h0BAD_F00D_CAFE_BEEF, ok);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("resp_reset.valid_before", {63'd0, o_rsp_valid[0]}, 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("resp_reset.valid_after", {63'd0, o_rsp_valid[0]}, 64'd0);
    reset = 1'b0;
    txn(0, 1'b0, 64'h28, 64'h0, 0, rd, err, lat);
    check("resp_reset.rd28", rd, 64'h0BAD_F00D_CAFE_BEEF);

    // LATENCY=0 instance.
    txn(1, 1'b1, 64'h40, 64'h0011_2233_4455_6677, 0, rd, err, lat);
    check("l0.wr40.latency", 64'(lat), 64'd0);
    txn(1, 1'b0, 64'h40, 64'h0, 0, rd, err, lat);
    check("l0.rd40", rd, 64'h0011_2233_4455_6677);

    // Back-to-back with rsp_ready held high: one accept every 2 cycles.
    begin
      int n, last, cyc;
      bit rdy;
      n = 0; last = -1; cyc = 0;
      d_rready[1] = 1'b1;
      d_write[1]  = b2b_w[0];
      d_addr[1]   = b2b_a[0];
      d_wdata[1]  = b2b_d[0];
      d_valid[1]  = 1'b1;
      while (n < 3 && cyc < 20) begin
        rdy = o_req_ready[1];
        @(posedge clock); #1;
        cyc++;
        if (rdy) begin
          if (last >= 0) check($sformatf("l0.b2b_spacing%0d", n), 64'(cyc - last), 64'd2);
          last = cyc;
          n++;
          if (n < 3) begin
            d_write[1] = b2b_w[n];
            d_addr[1]  = b2b_a[n];
            d_wdata[1] = b2b_d[n];
          end else begin
            d_valid[1] = 1'b0;
          end
        end
      end
      d_valid[1] = 1'b0;
      if (n < 3) check("l0.b2b_timeout", 64'(n), 64'd3);
      repeat (2) begin
        @(posedge clock); #1;
      end
      d_rready[1] = 1'b0;
    end
    txn(1, 1'b0, 64'h50, 64'h0, 0, rd, err, lat);
    check("l0.rd50", rd, 64'hCAFE_0000_2222_0050);

    @(posedge clock); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
